// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU.
//   OP_*       one-hot opcodes
//   state_t    control FSM states
//   popcount   number of set bits in a vector (up to POP_MAX_W bits, zero-extend narrower inputs)
package alu_pkg;

   localparam logic [5:0] OP_ADD = 6'b000001;
   localparam logic [5:0] OP_SUB = 6'b000010;
   localparam logic [5:0] OP_MUL = 6'b000100;
   localparam logic [5:0] OP_CNT = 6'b001000;
   localparam logic [5:0] OP_XOR = 6'b010000;
   localparam logic [5:0] OP_MAX = 6'b100000;

   localparam int POP_MAX_W = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic [7:0] popcount(input logic [POP_MAX_W-1:0] v);
      logic [7:0] c;
      c = '0;
      for (int i = 0; i < POP_MAX_W; i++) begin
         c = c + {7'd0, v[i]};
      end
      return c;
   endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier, one partial product per cycle.
//   clk, reset_n   clock, async active-low reset
//   start          load operands (also performs the first iteration)
//   signed_mode    1 = operands are two's complement
//   a, b           WIDTH-bit operands
//   busy           iterations still outstanding
//   done           one-cycle pulse when product is final
//   product        2*WIDTH-bit result, valid while done=1 and until the next start
module alu_mul_iter #(
   parameter int WIDTH = 5
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic                 signed_mode,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int RW = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH + 1);

   logic [WIDTH:0]  w_a_mag;
   logic [WIDTH:0]  w_b_mag;
   logic            w_neg;
   logic [RW-1:0]   w_pp;

   logic [RW-1:0]   r_mcand;
   logic [RW-1:0]   r_acc;
   logic [WIDTH:0]  r_mplier;
   logic            r_neg;
   logic [CW-1:0]   r_cnt;
   logic            r_busy;
   logic            r_done;

   // Magnitudes are formed in WIDTH+1 bits so that -2^(WIDTH-1) negates cleanly.
   always_comb begin
      w_a_mag = {1'b0, a};
      w_b_mag = {1'b0, b};
      if (signed_mode && a[WIDTH-1]) w_a_mag = -{1'b1, a};
      if (signed_mode && b[WIDTH-1]) w_b_mag = -{1'b1, b};
      w_neg = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
      w_pp  = r_mplier[0] ? r_mcand : '0;
   end

   // Control: the start cycle is iteration 1; busy cycles count iterations 2..WIDTH.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_cnt  <= '0;
      end else begin
         r_done <= 1'b0;
         if (start) begin
            r_busy <= 1'b1;
            r_cnt  <= CW'(1);
         end else if (r_busy) begin
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CW'(WIDTH - 1)) begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
            end
         end
      end
   end

   // Datapath: no reset needed, only observed through done.
   always_ff @(posedge clk) begin
      if (start) begin
         r_mcand  <= RW'(w_a_mag) << 1;
         r_acc    <= w_b_mag[0] ? RW'(w_a_mag) : '0;
         r_mplier <= w_b_mag >> 1;
         r_neg    <= w_neg;
      end else if (r_busy) begin
         r_acc    <= r_acc + w_pp;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
      end
   end

   assign busy    = r_busy;
   assign done    = r_done;
   assign product = r_neg ? -r_acc : r_acc;

endmodule

// File: rtl/seq_alu.sv
// Registered, handshaked ALU holding one operation in flight.
//   clk, reset_n          clock, async active-low reset
//   in_valid / in_ready   request handshake (operation, mode, in1, in2)
//   operation             one-hot opcode (alu_pkg::OP_*)
//   mode                  0 = unsigned, 1 = signed
//   out_valid / out_ready result handshake
//   out                   2*WIDTH-bit result
//   balance               even parity of out
//   equality              captured in1 == in2
//   illegal               opcode was not a legal one-hot code
module seq_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 5
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [5:0]           operation,
   input  logic                 mode,
   input  logic [WIDTH-1:0]     in1,
   input  logic [WIDTH-1:0]     in2,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out,
   output logic                 balance,
   output logic                 equality,
   output logic                 illegal
);

   localparam int RW = 2 * WIDTH;

   state_t          r_state;
   state_t          w_next;
   logic            r_eq_pend;
   logic            w_load_alu;
   logic            w_load_mul;
   logic            w_mul_start;
   logic            w_mul_busy;
   logic            w_mul_done;
   logic [RW-1:0]   w_mul_prod;
   logic [RW-1:0]   w_res;
   logic            w_ill;
   logic            w_gt;

   function automatic logic [RW-1:0] ext(input logic [WIDTH-1:0] v, input logic sgn);
      return sgn ? {{WIDTH{v[WIDTH-1]}}, v} : {{WIDTH{1'b0}}, v};
   endfunction

   // Single-cycle datapath, evaluated on the live inputs at the accept edge.
   always_comb begin
      w_res = '0;
      w_ill = 1'b0;
      w_gt  = mode ? ($signed(in1) > $signed(in2)) : (in1 > in2);
      case (operation)
         OP_ADD:  w_res = ext(in1, mode) + ext(in2, mode);
         OP_SUB:  w_res = ext(in1, mode) - ext(in2, mode);
         OP_MUL:  w_res = '0;
         OP_CNT:  w_res = RW'(popcount(POP_MAX_W'(in1))) + RW'(popcount(POP_MAX_W'(in2)));
         OP_XOR:  w_res = ext(in1 ^ in2, mode);
         OP_MAX:  w_res = ext(w_gt ? in1 : in2, mode);
         default: w_ill = 1'b1;
      endcase
   end

   always_comb begin
      w_next      = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      w_load_alu  = 1'b0;
      w_load_mul  = 1'b0;
      w_mul_start = 1'b0;
      case (r_state)
         IDLE: in_ready = 1'b1;
         MUL: begin
            if (w_mul_done && !w_mul_busy) begin
               w_next     = DONE;
               w_load_mul = 1'b1;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
            if (out_ready) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
      // An accept overrides the DONE->IDLE drain, giving back-to-back issue.
      if (in_valid && in_ready) begin
         if (operation == OP_MUL) begin
            w_next      = MUL;
            w_mul_start = 1'b1;
         end else begin
            w_next     = DONE;
            w_load_alu = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= IDLE;
         r_eq_pend <= 1'b0;
         out       <= '0;
         balance   <= 1'b0;
         equality  <= 1'b0;
         illegal   <= 1'b0;
      end else begin
         r_state <= w_next;
         // Equality must be remembered across the multiply iterations.
         if (w_mul_start) r_eq_pend <= (in1 == in2);
         if (w_load_alu) begin
            out      <= w_res;
            balance  <= ~^w_res;
            equality <= (in1 == in2);
            illegal  <= w_ill;
         end else if (w_load_mul) begin
            out      <= w_mul_prod;
            balance  <= ~^w_mul_prod;
            equality <= r_eq_pend;
            illegal  <= 1'b0;
         end
      end
   end

   alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (w_mul_start),
      .signed_mode (mode),
      .a           (in1),
      .b           (in2),
      .busy        (w_mul_busy),
      .done        (w_mul_done),
      .product     (w_mul_prod)
   );

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [5:0]  operation = 6'd0;
   logic        mode = 1'b0;
   logic [4:0]  in1 = 5'd0;
   logic [4:0]  in2 = 5'd0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [9:0]  out;
   logic        balance;
   logic        equality;
   logic        illegal;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   seq_alu #(.WIDTH(5)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .operation (operation),
      .mode      (mode),
      .in1       (in1),
      .in2       (in2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .balance   (balance),
      .equality  (equality),
      .illegal   (illegal)
   );

   // Present one request for one edge; returns at the negedge after the accept edge.
   task automatic issue(input logic [5:0] op, input logic m, input logic [4:0] a, input logic [4:0] b);
      @(negedge clk);
      operation = op; mode = m; in1 = a; in2 = b; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      @(negedge clk);
      n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else n_pass++;
      n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else n_pass++;
      n_total++; if (out !== 10'd0) $display("FAIL reset_out: got %h expected 000", out); else n_pass++;
      n_total++; if (illegal !== 1'b0) $display("FAIL reset_illegal: got %b expected 0", illegal); else n_pass++;
      reset_n = 1'b1;
   endtask

   task automatic test_add();
      issue(OP_ADD, 1'b0, 5'd31, 5'd31);
      n_total++; if (out_valid !== 1'b1) $display("FAIL add_valid: got %b expected 1", out_valid); else n_pass++;
      n_total++; if (out !== 10'd62) $display("FAIL add_out: got %0d expected 62", out); else n_pass++;
      n_total++; if (balance !== 1'b0) $display("FAIL add_balance: got %b expected 0", balance); else n_pass++;
      n_total++; if (equality !== 1'b1) $display("FAIL add_equality: got %b expected 1", equality); else n_pass++;
      n_total++; if (illegal !== 1'b0) $display("FAIL add_illegal: got %b expected 0", illegal); else n_pass++;
      drain();
      n_total++; if (out_valid !== 1'b0) $display("FAIL add_drain: got %b expected 0", out_valid); else n_pass++;
   endtask

   task automatic test_sub();
      issue(OP_SUB, 1'b1, 5'd3, 5'd5);
      n_total++; if (out !== 10'h3FE) $display("FAIL sub_signed: got %h expected 3fe", out); else n_pass++;
      n_total++; if (balance !== 1'b0) $display("FAIL sub_balance: got %b expected 0", balance); else n_pass++;
      n_total++; if (equality !== 1'b0) $display("FAIL sub_equality: got %b expected 0", equality); else n_pass++;
      drain();
      issue(OP_SUB, 1'b0, 5'd3, 5'd5);
      n_total++; if (out !== 10'h3FE) $display("FAIL sub_unsigned: got %h expected 3fe", out); else n_pass++;
      drain();
   endtask

   task automatic mul_run(input string name, input logic m, input logic [4:0] a, input logic [4:0] b,
                          input logic [9:0] exp);
      int lat;
      logic busy_ok;
      lat = 0;
      busy_ok = 1'b1;
      @(negedge clk);
      operation = OP_MUL; mode = m; in1 = a; in2 = b; in_valid = 1'b1;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         @(negedge clk);
         in_valid = 1'b0;
         if (out_valid) begin
            lat = cyc;
            break;
         end
         if (in_ready !== 1'b0) busy_ok = 1'b0;
      end
      n_total++; if (lat != 6) $display("FAIL %s_latency: got %0d expected 6", name, lat); else n_pass++;
      n_total++; if (out !== exp) $display("FAIL %s_out: got %h expected %h", name, out, exp); else n_pass++;
      n_total++; if (busy_ok !== 1'b1) $display("FAIL %s_in_ready_busy: got 1 expected 0", name); else n_pass++;
      drain();
   endtask

   task automatic test_mul();
      mul_run("mul_neg_neg", 1'b1, 5'h10, 5'h10, 10'd256);
      mul_run("mul_neg_pos", 1'b1, 5'h10, 5'd7, 10'h390);
      mul_run("mul_unsigned", 1'b0, 5'd31, 5'd31, 10'd961);
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      @(negedge clk);
      operation = OP_XOR; mode = 1'b0; in1 = 5'h15; in2 = 5'h0A; in_valid = 1'b1;
      @(negedge clk);
      n_total++; if (out !== 10'd31) $display("FAIL b2b_xor: got %0d expected 31", out); else n_pass++;
      n_total++; if (in_ready !== 1'b1) $display("FAIL b2b_ready1: got %b expected 1", in_ready); else n_pass++;
      operation = OP_MAX; mode = 1'b1; in1 = 5'h0F; in2 = 5'h10;
      @(negedge clk);
      n_total++; if (out !== 10'd15) $display("FAIL b2b_max: got %0d expected 15", out); else n_pass++;
      n_total++; if (out_valid !== 1'b1) $display("FAIL b2b_valid: got %b expected 1", out_valid); else n_pass++;
      // Stall: a new request must be ignored and the result held.
      out_ready = 1'b0;
      operation = OP_ADD; mode = 1'b0; in1 = 5'd1; in2 = 5'd2;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_total++; if (out !== 10'd15 || out_valid !== 1'b1) $display("FAIL stall_hold: got %0d/%b expected 15/1", out, out_valid); else n_pass++;
         n_total++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready: got %b expected 0", in_ready); else n_pass++;
      end
      in_valid = 1'b0;
      drain();
   endtask

   task automatic test_illegal();
      issue(6'b000011, 1'b0, 5'd3, 5'd5);
      n_total++; if (out_valid !== 1'b1) $display("FAIL ill_valid: got %b expected 1", out_valid); else n_pass++;
      n_total++; if (out !== 10'd0) $display("FAIL ill_out: got %h expected 000", out); else n_pass++;
      n_total++; if (illegal !== 1'b1) $display("FAIL ill_flag: got %b expected 1", illegal); else n_pass++;
      n_total++; if (balance !== 1'b1) $display("FAIL ill_balance: got %b expected 1", balance); else n_pass++;
      drain();
      issue(OP_CNT, 1'b0, 5'h1F, 5'h01);
      n_total++; if (out !== 10'd6) $display("FAIL cnt_out: got %0d expected 6", out); else n_pass++;
      n_total++; if (illegal !== 1'b0) $display("FAIL cnt_illegal: got %b expected 0", illegal); else n_pass++;
      drain();
   endtask

   task automatic test_reset_mid_mul();
      logic spurious;
      spurious = 1'b0;
      issue(OP_ADD, 1'b0, 5'd9, 5'd4);
      drain();
      issue(OP_MUL, 1'b0, 5'd3, 5'd5);
      @(negedge clk);
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      n_total++; if (out_valid !== 1'b0) $display("FAIL rst_mul_valid: got %b expected 0", out_valid); else n_pass++;
      n_total++; if (in_ready !== 1'b1) $display("FAIL rst_mul_ready: got %b expected 1", in_ready); else n_pass++;
      n_total++; if (out !== 10'd0) $display("FAIL rst_mul_out: got %h expected 000", out); else n_pass++;
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_valid !== 1'b0) spurious = 1'b1;
      end
      n_total++; if (spurious !== 1'b0) $display("FAIL rst_mul_spurious: got 1 expected 0"); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_mul();
      test_back_to_back();
      test_illegal();
      test_reset_mid_mul();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
